mod_accum_4027: RTL and testbench
=================================

Name: mod_accum_4027

Overview:
- Streaming modular accumulator. Sits directly downstream of the q=4027 Barrett reduction stage and consumes its 12-bit residues.
- Sums FRAME_LEN consecutive residues modulo Q and emits one reduced 12-bit frame sum per frame.
- Uses valid/ready handshakes on both sides, so it can stall the reducer pipeline or be stalled by the consumer.

Parameters:
- Q, 4027, modulus; must be < 4096 and > 2048 so that a single conditional subtract fully reduces any 12-bit input.
- FRAME_LEN, 16, residues per frame; legal range 1..255.
- CNT_W, 8, width of the internal sample counter; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream residue valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  12  residue from the Barrett stage, nominally < Q.
- out_valid  out  1  frame sum valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  12  frame sum mod Q, always < Q.
- range_err  out  1  sticky flag: an input >= Q was seen since reset.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=ACC, acc=0, cnt=0, out_valid=0, out_data=0, range_err=0. in_ready=1 in the first cycle after reset.
- rst has priority over every other event. Reset mid-frame discards the partial sum and any pending output.
- Transfer rules:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Input normalisation (combinational):
  - x = in_data >= Q ? in_data - Q : in_data.
  - On an accepted input with in_data >= Q, range_err is set and stays set until rst.
- Modular add:
  - s = acc + x, 13-bit.
  - r = s >= Q ? s - Q : s.
  - r is always < Q.
- States:
  - ACC: in_ready=1, out_valid=0.
    - On input transfer with cnt < FRAME_LEN-1: acc<=r, cnt<=cnt+1.
    - On input transfer with cnt == FRAME_LEN-1: out_data<=r, out_valid<=1, acc<=0, cnt<=0, go to HOLD.
  - HOLD: out_valid=1; out_data held stable while out_ready=0; in_ready=out_ready (combinational pass-through).
    - out_ready=0: nothing changes.
    - Output transfer with no input transfer: out_valid<=0, go to ACC.
    - Output transfer with simultaneous input transfer: the new sample starts the next frame (acc<=x, cnt<=1), then go to ACC.
    - If FRAME_LEN==1, that same simultaneous sample instead completes a frame: out_data<=x, stay in HOLD.
- Latency: out_valid rises the cycle after the last sample of a frame is accepted.
- Throughput: with out_ready tied high, one sample per cycle, no bubbles between frames.
- No combinational path from in_valid to out_*. The only combinational path is out_ready -> in_ready, in HOLD.
- Input must not be accepted while an unconsumed result is pending; the HOLD rule guarantees this, so results never overwrite.

Test Plan:
- Reset, then 16 back-to-back samples of 1 with out_ready=1 -> exactly one out_valid pulse with out_data=16, range_err=0.
- 16 samples of 4026 -> out_data=4011 (16·(−1) mod 4027). Checks the wrap subtract on every add.
- Frame of 16 samples of 2 with out_ready=0 for 5 cycles after completion -> out_valid=1 and out_data=32 stable, in_ready=0. Then raise out_ready with in_valid=1 and 16 more samples of 3 -> first frame accepted, next out_data=48, no sample lost.
- Single sample in_data=4095 inside a frame of zeros -> range_err=1 and stays 1, out_data=68.
- Accept 7 samples of 100, assert rst for 1 cycle, then 16 samples of 5 -> out_data=80. The pre-reset partial sum must not appear.
- FRAME_LEN=1 build, continuous in_valid, out_ready=1, inputs 10, 4030, 7 -> out_data sequence 10, 3, 7 on consecutive cycles, range_err=1 after the second sample.

Source files
------------

// File: rtl/mod_accum_4027.sv
// Streaming modular accumulator: sums FRAME_LEN residues mod Q and emits one reduced sum per
// frame over valid/ready handshakes on both sides.
module mod_accum_4027 #(
    parameter int unsigned Q         = 4027,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data,
    output logic        range_err
);

    localparam logic [11:0]      QV       = 12'(Q);
    localparam logic [12:0]      QS       = 13'(Q);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam bit               SINGLE   = (FRAME_LEN == 1);

    typedef enum logic [0:0] {StAcc, StHold} state_e;

    state_e           state_q, state_d;
    logic [11:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      out_data_q, out_data_d;
    logic             range_err_q, range_err_d;

    logic        in_fire, out_fire, in_high;
    logic [11:0] x, r;
    logic [12:0] s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAcc;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            range_err_q <= range_err_d;
        end
    end

    // Q > 2048 guarantees one conditional subtract reduces any 12-bit value or 13-bit sum.
    always_comb begin
        in_high = (in_data >= QV);
        x       = in_high ? (in_data - QV) : in_data;
        s       = {1'b0, acc_q} + {1'b0, x};
        r       = (s >= QS) ? 12'(s - QS) : s[11:0];
    end

    always_comb begin
        out_valid = (state_q == StHold);
        // In HOLD a new sample may only enter in the same cycle the pending result leaves.
        in_ready  = (state_q == StAcc) ? 1'b1 : out_ready;
        out_data  = out_data_q;
        range_err = range_err_q;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        range_err_d = range_err_q | (in_fire & in_high);

        unique case (state_q)
            StAcc: begin
                if (in_fire) begin
                    if (cnt_q == LAST_CNT) begin
                        out_data_d = r;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = StHold;
                    end else begin
                        acc_d = r;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StHold: begin
                if (out_fire) begin
                    if (in_fire) begin
                        if (SINGLE) begin
                            out_data_d = x;
                        end else begin
                            acc_d   = x;
                            cnt_d   = CNT_W'(1);
                            state_d = StAcc;
                        end
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            default: state_d = StAcc;
        endcase
    end

endmodule

// File: tb/tb_mod_accum_4027.sv
// Bench for mod_accum_4027: directed frames plus random traffic scored against an arithmetic
// model of frame sums; a second FRAME_LEN=1 instance covers the single-sample frame case.
module tb_mod_accum_4027;

    localparam int Q  = 4027;
    localparam int FL = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [11:0] in_data = '0;
    logic        in_ready, out_valid, range_err;
    logic [11:0] out_data;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic [11:0] in_data1 = '0;
    logic        in_ready1, out_valid1, range_err1;
    logic [11:0] out_data1;

    mod_accum_4027 dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .range_err(range_err)
    );

    mod_accum_4027 #(.FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .range_err(range_err1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: raw accepted inputs summed as integers, reduced mod Q once per frame.
    int exp_q[$];
    int acc_m = 0, cnt_m = 0;
    bit err_m = 1'b0;
    bit armed = 1'b0;
    int n_out = 0;
    int last_out = -1;

    always @(negedge clk) begin
        if (armed) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) check("out_data", {20'b0, out_data}, exp_q[0]);
            check("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() == 0) || out_ready});
            check("range_err", {31'b0, range_err}, {31'b0, err_m});
        end
        if (rst) begin
            exp_q.delete();
            acc_m = 0;
            cnt_m = 0;
            err_m = 1'b0;
            armed = 1'b1;
        end else if (armed) begin
            if (out_valid && out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                last_out = int'(out_data);
                n_out++;
            end
            if (in_valid && in_ready) begin
                if (int'(in_data) >= Q) err_m = 1'b1;
                acc_m += int'(in_data);
                cnt_m++;
                if (cnt_m == FL) begin
                    exp_q.push_back(acc_m % Q);
                    acc_m = 0;
                    cnt_m = 0;
                end
            end
        end
    end

    task automatic send(input logic [11:0] v);
        int n = 0;
        bit ok;
        in_valid = 1'b1;
        in_data  = v;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_out(input int n0);
        int k = 0;
        while (n_out == n0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (n_out == n0) check("out_timeout", 0, 1);
    endtask

    task automatic pulse_rst();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and single-sample-frame instance.
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_data", {20'b0, out_data}, 0);
        check("rst_in_ready", {31'b0, in_ready}, 1);
        check("rst_range_err", {31'b0, range_err}, 0);
        check("f1_in_ready", {31'b0, in_ready1}, 1);
        in_valid1 = 1'b1;
        in_data1  = 12'd10;
        @(posedge clk);
        #1 in_data1 = 12'd4030;
        @(negedge clk);
        check("f1_valid_a", {31'b0, out_valid1}, 1);
        check("f1_data_a", {20'b0, out_data1}, 10);
        check("f1_ready_a", {31'b0, in_ready1}, 1);
        check("f1_err_a", {31'b0, range_err1}, 0);
        @(posedge clk);
        #1 in_data1 = 12'd7;
        @(negedge clk);
        check("f1_data_b", {20'b0, out_data1}, 3);
        check("f1_err_b", {31'b0, range_err1}, 1);
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        @(negedge clk);
        check("f1_data_c", {20'b0, out_data1}, 7);
        check("f1_valid_c", {31'b0, out_valid1}, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("f1_valid_d", {31'b0, out_valid1}, 0);
        check("f1_err_d", {31'b0, range_err1}, 1);
        @(posedge clk);
        #1;

        // Sixteen ones: exactly one result of 16.
        n0 = n_out;
        repeat (16) send(12'd1);
        in_valid = 1'b0;
        wait_out(n0);
        check("ones_sum", last_out, 16);
        repeat (20) @(posedge clk);
        #1;
        check("ones_count", n_out - n0, 1);
        check("ones_err", {31'b0, range_err}, 0);

        // Wrap on every add.
        n0 = n_out;
        repeat (16) send(12'd4026);
        in_valid = 1'b0;
        wait_out(n0);
        check("wrap_sum", last_out, 4011);

        // Stall downstream, then release with input already waiting.
        out_ready = 1'b0;
        repeat (16) send(12'd2);
        in_valid = 1'b1;
        in_data  = 12'd3;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_valid", {31'b0, out_valid}, 1);
        check("stall_data", {20'b0, out_data}, 32);
        check("stall_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(12'd3);
        check("stall_first", last_out, 32);
        n0 = n_out;
        repeat (15) send(12'd3);
        in_valid = 1'b0;
        wait_out(n0);
        check("stall_second", last_out, 48);

        // Out-of-range sample inside a frame of zeros.
        n0 = n_out;
        repeat (5) send(12'd0);
        send(12'd4095);
        repeat (10) send(12'd0);
        in_valid = 1'b0;
        wait_out(n0);
        check("range_sum", last_out, 68);
        check("range_err_set", {31'b0, range_err}, 1);
        n0 = n_out;
        repeat (16) send(12'd0);
        in_valid = 1'b0;
        wait_out(n0);
        check("range_zero", last_out, 0);
        check("range_err_sticky", {31'b0, range_err}, 1);

        // Reset mid-frame discards the partial sum and clears the sticky flag.
        pulse_rst();
        repeat (7) send(12'd100);
        pulse_rst();
        n0 = n_out;
        repeat (16) send(12'd5);
        in_valid = 1'b0;
        wait_out(n0);
        check("reset_sum", last_out, 80);
        check("reset_err", {31'b0, range_err}, 0);

        // Random traffic with occasional resets, scored by the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst       = ($urandom % 300) == 0;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            case ($urandom % 4)
                0: in_data = 12'($urandom_range(4095, Q - 4));
                1: in_data = 12'd0;
                default: in_data = 12'($urandom % 4096);
            endcase
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        check("random_frames_seen", {31'b0, n_out > 40}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
